// File: rtl/prog_ram_arbiter_if.sv
// Bus bundle between the CPU fetch path, the program loader and the program BRAM port A.
// The arbiter takes the slave view; requesters and RAM together take the master view.
interface prog_ram_arbiter_if #(
    parameter int unsigned AW = 11,
    parameter int unsigned DW = 8
);
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          ld_req;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_lock;
    logic          ld_gnt;
    logic          ld_rvalid;
    logic [DW-1:0] ld_rdata;

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_q;

    modport slave (
        input  cpu_req, cpu_addr,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
        output ld_gnt, ld_rvalid, ld_rdata,
        output mem_addr, mem_we, mem_wdata,
        input  mem_q
    );

    modport master (
        output cpu_req, cpu_addr,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
        input  ld_gnt, ld_rvalid, ld_rdata,
        input  mem_addr, mem_we, mem_wdata,
        output mem_q
    );
endinterface

// File: rtl/prog_ram_arbiter.sv
// Shares program BRAM port A between CPU fetch (read-only) and the loader (read/write),
// alternating under contention unless the loader holds its lock; counts CPU stall cycles.
module prog_ram_arbiter #(
    parameter int unsigned AW = 11,
    parameter int unsigned DW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    prog_ram_arbiter_if.slave    bus,
    input  logic                 stall_clr,
    output logic [7:0]           stall_cnt
);
    typedef enum logic [1:0] {
        LAST_IDLE,
        LAST_CPU,
        LAST_LD
    } last_t;

    last_t last_q;
    last_t last_d;
    logic  cpu_gnt;
    logic  ld_gnt;

    // Under contention the CPU wins unless the loader is locked or the CPU had the previous slot.
    always_comb begin
        cpu_gnt = 1'b0;
        ld_gnt  = 1'b0;
        if (bus.cpu_req && bus.ld_req) begin
            if (bus.ld_lock || (last_q == LAST_CPU)) begin
                ld_gnt = 1'b1;
            end else begin
                cpu_gnt = 1'b1;
            end
        end else begin
            cpu_gnt = bus.cpu_req;
            ld_gnt  = bus.ld_req;
        end

        last_d = LAST_IDLE;
        if (cpu_gnt) begin
            last_d = LAST_CPU;
        end else if (ld_gnt) begin
            last_d = LAST_LD;
        end
    end

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        if (cpu_gnt) begin
            bus.mem_addr = bus.cpu_addr;
        end else if (ld_gnt) begin
            bus.mem_addr  = bus.ld_addr;
            bus.mem_we    = bus.ld_we;
            bus.mem_wdata = bus.ld_wdata;
        end
    end

    assign bus.cpu_gnt   = cpu_gnt;
    assign bus.ld_gnt    = ld_gnt;
    assign bus.cpu_rdata = bus.mem_q;
    assign bus.ld_rdata  = bus.mem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q         <= LAST_IDLE;
            bus.cpu_rvalid <= 1'b0;
            bus.ld_rvalid  <= 1'b0;
        end else begin
            last_q         <= last_d;
            bus.cpu_rvalid <= cpu_gnt;
            bus.ld_rvalid  <= ld_gnt & ~bus.ld_we;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (bus.cpu_req && !cpu_gnt && (stall_cnt != 8'hFF)) begin
            stall_cnt <= stall_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_prog_ram_arbiter.sv
// Bench for prog_ram_arbiter: directed scenarios then random traffic against a rule-level model
// with its own shadow memory; the bench also plays the write-first program BRAM.
module tb_prog_ram_arbiter;
    localparam int unsigned AW = 11;
    localparam int unsigned DW = 8;

    logic       clk;
    logic       rst_n;
    logic       stall_clr;
    logic [7:0] stall_cnt;

    prog_ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    prog_ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .stall_clr (stall_clr),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.mem_we) begin
            ram[bus.mem_addr] = bus.mem_wdata;
            bus.mem_q <= bus.mem_wdata;
        end else begin
            bus.mem_q <= ram[bus.mem_addr];
        end
    end

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model: owner of the previous slot (0 none, 1 cpu, 2 loader), shadow memory, stall count
    int            m_last  = 0;
    int            m_stall = 0;
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with inputs already driven; checks one full cycle.
    task automatic cycle();
        bit            gc, gl;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] d_c, d_l;
        #1;
        gc = 1'b0;
        gl = 1'b0;
        if (bus.cpu_req && bus.ld_req) begin
            if (bus.ld_lock || m_last == 1) gl = 1'b1;
            else                            gc = 1'b1;
        end else begin
            gc = bus.cpu_req;
            gl = bus.ld_req;
        end
        e_addr = gc ? bus.cpu_addr : (gl ? bus.ld_addr : '0);
        check("cpu_gnt", 32'(bus.cpu_gnt), 32'(gc));
        check("ld_gnt", 32'(bus.ld_gnt), 32'(gl));
        check("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
        check("mem_we", 32'(bus.mem_we), 32'(gl && bus.ld_we));
        check("mem_wdata", 32'(bus.mem_wdata), gl ? 32'(bus.ld_wdata) : 32'd0);

        d_c = '0;
        d_l = '0;
        if (gc) d_c = ref_mem[bus.cpu_addr];
        if (gl) begin
            if (bus.ld_we) ref_mem[bus.ld_addr] = bus.ld_wdata;
            else           d_l = ref_mem[bus.ld_addr];
        end
        if (stall_clr)                 m_stall = 0;
        else if (bus.cpu_req && !gc)   m_stall = (m_stall < 255) ? m_stall + 1 : 255;
        m_last = gc ? 1 : (gl ? 2 : 0);

        @(posedge clk);
        @(negedge clk);
        check("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(gc));
        check("ld_rvalid", 32'(bus.ld_rvalid), 32'(gl && !bus.ld_we));
        if (gc)               check("cpu_rdata", 32'(bus.cpu_rdata), 32'(d_c));
        if (gl && !bus.ld_we) check("ld_rdata", 32'(bus.ld_rdata), 32'(d_l));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    endtask

    task automatic idle_inputs();
        bus.cpu_req  = 1'b0;
        bus.cpu_addr = '0;
        bus.ld_req   = 1'b0;
        bus.ld_we    = 1'b0;
        bus.ld_addr  = '0;
        bus.ld_wdata = '0;
        bus.ld_lock  = 1'b0;
        stall_clr    = 1'b0;
    endtask

    // Holds reset across one rising edge with idle inputs.
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        m_last  = 0;
        m_stall = 0;
        @(posedge clk);
        @(negedge clk);
        check("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        check("rst_ld_rvalid", 32'(bus.ld_rvalid), 32'd0);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
        @(negedge clk);
        do_reset();

        // Preload the low addresses through the loader
        for (int i = 0; i < 32; i++) begin
            bus.ld_req   = 1'b1;
            bus.ld_we    = 1'b1;
            bus.ld_addr  = AW'(i);
            bus.ld_wdata = (i == 5) ? 8'h42 : DW'($urandom);
            cycle();
        end
        idle_inputs();
        do_reset();

        // CPU fetch of RAM[5]
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 11'h005;
        cycle();
        check("fetch5_data", 32'(bus.cpu_rdata), 32'h42);
        check("fetch5_stall", 32'(stall_cnt), 32'd0);
        idle_inputs();

        // Loader write then read-back of 0x010
        bus.ld_req   = 1'b1;
        bus.ld_we    = 1'b1;
        bus.ld_addr  = 11'h010;
        bus.ld_wdata = 8'hA5;
        cycle();
        bus.ld_we = 1'b0;
        cycle();
        check("wr_rd_data", 32'(bus.ld_rdata), 32'hA5);
        idle_inputs();

        // Six cycles of contention from reset alternate starting with CPU
        do_reset();
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 11'h003;
        bus.ld_req   = 1'b1;
        bus.ld_addr  = 11'h004;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("alt_gnt_seq", 32'(m_last), (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        check("alt_stall3", 32'(stall_cnt), 32'd3);

        // Locked loader starves the CPU until the counter saturates
        bus.ld_lock = 1'b1;
        for (int i = 0; i < 300; i++) cycle();
        check("lock_sat", 32'(stall_cnt), 32'hFF);
        bus.ld_lock = 1'b0;
        cycle();
        check("unlock_cpu", 32'(m_last), 32'd1);
        bus.cpu_req = 1'b0;
        bus.ld_req  = 1'b0;
        stall_clr   = 1'b1;
        cycle();
        check("stall_clr", 32'(stall_cnt), 32'd0);
        idle_inputs();

        // Reset held across the edge of a granted CPU read suppresses its rvalid
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 11'h007;
        #1;
        check("rst_mid_gnt", 32'(bus.cpu_gnt), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        check("rst_mid_stall", 32'(stall_cnt), 32'd0);
        m_last  = 0;
        m_stall = 0;
        rst_n = 1'b1;
        bus.ld_req  = 1'b1;
        bus.ld_addr = 11'h002;
        cycle();
        check("rst_mid_tie_cpu", 32'(m_last), 32'd1);

        // Idle cycle: no drive, no rvalid, counter unchanged
        idle_inputs();
        cycle();
        check("idle_addr", 32'(bus.mem_addr), 32'd0);

        // Random traffic over a small address window
        for (int i = 0; i < 500; i++) begin
            bus.cpu_req  = ($urandom_range(0, 3) != 0);
            bus.cpu_addr = AW'($urandom_range(0, 31));
            bus.ld_req   = ($urandom_range(0, 3) != 0);
            bus.ld_we    = $urandom_range(0, 1) != 0;
            bus.ld_addr  = AW'($urandom_range(0, 31));
            bus.ld_wdata = DW'($urandom);
            bus.ld_lock  = ($urandom_range(0, 7) == 0);
            stall_clr    = ($urandom_range(0, 31) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
